// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the 5-stage datapath.
// The datapath side uses master; the sequencer uses slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_MemRead;
    logic [4:0]       ex_rd;
    logic             mem_Branch;
    logic             mem_zero;
    logic             mem_MemRead;
    logic             mem_MemWrite;
    logic             dmem_ready;
    logic             pc_src;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_hold;
    logic             exmem_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
               mem_Branch, mem_zero, mem_MemRead, mem_MemWrite, dmem_ready,
        input  pc_src, pc_hold, ifid_hold, idex_hold, exmem_hold,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               dmem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
               mem_Branch, mem_zero, mem_MemRead, mem_MemWrite, dmem_ready,
        output pc_src, pc_hold, ifid_hold, idex_hold, exmem_hold,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               dmem_req, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and data-memory
// wait states with timeout, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic br_taken, mem_op, lu_haz;
    logic pc_src, pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, dmem_req;
    logic go_wait, release_wait, timed_out;

    assign br_taken = bus.mem_Branch & bus.mem_zero;
    assign mem_op   = bus.mem_MemRead | bus.mem_MemWrite;
    assign lu_haz   = bus.ex_MemRead && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Control outputs respond in the same cycle as their cause; everything is forced low in reset.
    always_comb begin
        pc_src       = 1'b0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        go_wait      = 1'b0;
        release_wait = 1'b0;
        timed_out    = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (mem_op) begin
                        dmem_req = 1'b1;
                        if (!bus.dmem_ready) begin
                            pc_hold      = 1'b1;
                            ifid_hold    = 1'b1;
                            idex_hold    = 1'b1;
                            exmem_hold   = 1'b1;
                            memwb_bubble = 1'b1;
                            go_wait      = 1'b1;
                        end
                    end else if (lu_haz) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (bus.dmem_ready) begin
                        release_wait = 1'b1;
                    end else if (wait_cnt < TIMEOUT) begin
                        pc_hold      = 1'b1;
                        ifid_hold    = 1'b1;
                        idex_hold    = 1'b1;
                        exmem_hold   = 1'b1;
                        memwb_bubble = 1'b1;
                    end else begin
                        release_wait = 1'b1;
                        timed_out    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The RUN cycle that first sees the stalled access counts as wait cycle 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (go_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (release_wait) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
            if (timed_out) begin
                mem_err_q <= 1'b1;
            end
            if (pc_hold && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (pc_src && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.pc_src       = pc_src;
    assign bus.pc_hold      = pc_hold;
    assign bus.ifid_hold    = ifid_hold;
    assign bus.idex_hold    = idex_hold;
    assign bus.exmem_hold   = exmem_hold;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.dmem_req     = dmem_req;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and small CNT_W/MEM_TIMEOUT)
// share stimulus and are compared every cycle against an abstract model.
module tb_pipe_hazard_ctrl;
    localparam logic [9:0] O_SRC = 10'b1000000000;
    localparam logic [9:0] O_PCH = 10'b0100000000;
    localparam logic [9:0] O_IFH = 10'b0010000000;
    localparam logic [9:0] O_IDH = 10'b0001000000;
    localparam logic [9:0] O_EXH = 10'b0000100000;
    localparam logic [9:0] O_IFF = 10'b0000010000;
    localparam logic [9:0] O_IDF = 10'b0000001000;
    localparam logic [9:0] O_EXF = 10'b0000000100;
    localparam logic [9:0] O_BUB = 10'b0000000010;
    localparam logic [9:0] O_REQ = 10'b0000000001;
    localparam logic [9:0] LU    = O_PCH | O_IFH | O_IDF;
    localparam logic [9:0] BR    = O_SRC | O_IFF | O_IDF | O_EXF;
    localparam logic [9:0] WAIT  = O_PCH | O_IFH | O_IDH | O_EXH | O_BUB | O_REQ;

    typedef struct {
        logic [4:0] rs1, rs2, exrd;
        logic       use1, use2, exmr, br, zero, mr, mw, rdy;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_hazard_ctrl_if #(.CNT_W(3))  bus_b ();

    pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    pipe_hazard_ctrl #(.CNT_W(3),  .MEM_TIMEOUT(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    // Model state per instance: index 0 = default, 1 = small
    vec_t cur;
    bit   cur_rst;
    bit   m_wait[2];
    int   m_waited[2];
    bit   m_err[2];
    int   m_stall[2];
    int   m_flush[2];
    int   to_lim[2]  = '{64, 4};
    int   cnt_max[2] = '{65535, 7};

    function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic use1, logic use2,
                                logic exmr, logic [4:0] exrd, logic br, logic zero,
                                logic mr, logic mw, logic rdy, logic [9:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.exmr = exmr; v.exrd = exrd; v.br = br; v.zero = zero;
        v.mr = mr; v.mw = mw; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [9:0] model_out(int k);
        bit lu;
        lu = cur.exmr && cur.exrd != 0 &&
             ((cur.use1 && cur.rs1 == cur.exrd) || (cur.use2 && cur.rs2 == cur.exrd));
        if (!cur_rst) return '0;
        if (m_wait[k]) begin
            if (cur.rdy || m_waited[k] >= to_lim[k]) return O_REQ;
            return WAIT;
        end
        if (cur.br && cur.zero) return BR;
        if (cur.mr || cur.mw) return cur.rdy ? O_REQ : WAIT;
        if (lu) return LU;
        return '0;
    endfunction

    function automatic void model_update(int k, logic [9:0] o);
        if (!cur_rst) begin
            m_wait[k] = 0; m_waited[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            return;
        end
        if ((o & O_PCH) != 0 && m_stall[k] < cnt_max[k]) m_stall[k]++;
        if ((o & O_SRC) != 0 && m_flush[k] < cnt_max[k]) m_flush[k]++;
        if (m_wait[k]) begin
            if (cur.rdy || m_waited[k] >= to_lim[k]) begin
                if (!cur.rdy) m_err[k] = 1;
                m_wait[k] = 0;
            end else begin
                m_waited[k]++;
            end
        end else if (!(cur.br && cur.zero) && (cur.mr || cur.mw) && !cur.rdy) begin
            m_wait[k] = 1;
            m_waited[k] = 1;
        end
    endfunction

    function automatic logic [9:0] dut_out(int k);
        if (k == 0)
            return {bus_a.pc_src, bus_a.pc_hold, bus_a.ifid_hold, bus_a.idex_hold, bus_a.exmem_hold,
                    bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_flush, bus_a.memwb_bubble,
                    bus_a.dmem_req};
        return {bus_b.pc_src, bus_b.pc_hold, bus_b.ifid_hold, bus_b.idex_hold, bus_b.exmem_hold,
                bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush, bus_b.memwb_bubble,
                bus_b.dmem_req};
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(vec_t v, bit rst_val);
        @(negedge clk);
        cur = v; cur_rst = rst_val; rst_n = rst_val;
        bus_a.id_rs1 = v.rs1;  bus_b.id_rs1 = v.rs1;
        bus_a.id_rs2 = v.rs2;  bus_b.id_rs2 = v.rs2;
        bus_a.id_use_rs1 = v.use1; bus_b.id_use_rs1 = v.use1;
        bus_a.id_use_rs2 = v.use2; bus_b.id_use_rs2 = v.use2;
        bus_a.ex_MemRead = v.exmr; bus_b.ex_MemRead = v.exmr;
        bus_a.ex_rd = v.exrd;      bus_b.ex_rd = v.exrd;
        bus_a.mem_Branch = v.br;   bus_b.mem_Branch = v.br;
        bus_a.mem_zero = v.zero;   bus_b.mem_zero = v.zero;
        bus_a.mem_MemRead = v.mr;  bus_b.mem_MemRead = v.mr;
        bus_a.mem_MemWrite = v.mw; bus_b.mem_MemWrite = v.mw;
        bus_a.dmem_ready = v.rdy;  bus_b.dmem_ready = v.rdy;
        #1;
    endtask

    // Compare controls before the edge, then counters and mem_err just after it.
    task automatic checkCycle();
        logic [9:0] e0, e1;
        e0 = model_out(0);
        e1 = model_out(1);
        checkOutput("comb_a", 32'(dut_out(0)), 32'(e0));
        checkOutput("comb_b", 32'(dut_out(1)), 32'(e1));
        @(posedge clk);
        model_update(0, e0);
        model_update(1, e1);
        #1;
        checkOutput("stall_a", 32'(bus_a.stall_cnt), m_stall[0]);
        checkOutput("flush_a", 32'(bus_a.flush_cnt), m_flush[0]);
        checkOutput("err_a",   32'(bus_a.mem_err),   32'(m_err[0]));
        checkOutput("stall_b", 32'(bus_b.stall_cnt), m_stall[1]);
        checkOutput("flush_b", 32'(bus_b.flush_cnt), m_flush[1]);
        checkOutput("err_b",   32'(bus_b.mem_err),   32'(m_err[1]));
    endtask

    task automatic step(vec_t v, bit rst_val);
        applyStimulus(v, rst_val);
        checkCycle();
    endtask

    vec_t tbl[12];
    vec_t idle, ld_wait, ld_use;
    int   cnt;

    initial begin
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        ld_wait = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, WAIT);
        ld_use  = mk(1, 5, 0, 1, 1, 5, 0, 0, 0, 0, 1, LU);

        tbl[0]  = idle;
        tbl[1]  = ld_use;
        tbl[2]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, '0);
        tbl[3]  = mk(7, 2, 0, 1, 1, 7, 0, 0, 0, 0, 1, '0);
        tbl[4]  = mk(9, 3, 1, 0, 1, 9, 0, 0, 0, 0, 1, LU);
        tbl[5]  = mk(9, 3, 1, 1, 0, 9, 0, 0, 0, 0, 1, '0);
        tbl[6]  = mk(1, 5, 0, 1, 1, 5, 1, 1, 0, 0, 1, BR);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, '0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_REQ);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, BR);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_REQ);
        tbl[11] = mk(1, 5, 0, 1, 1, 5, 1, 0, 0, 0, 1, LU);

        step(idle, 0);
        step(idle, 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], 1);
            checkOutput($sformatf("table%0d", i), 32'(dut_out(0)), 32'(tbl[i].exp));
            checkCycle();
        end
        checkOutput("table_stalls", 32'(bus_a.stall_cnt), 32'd3);
        checkOutput("table_flushes", 32'(bus_a.flush_cnt), 32'd2);

        // Three not-ready cycles then completion
        step(idle, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ld_wait.rdy = (i == 3);
            applyStimulus(ld_wait, 1);
            if (bus_a.dmem_req) cnt++;
            checkCycle();
        end
        ld_wait.rdy = 0;
        step(idle, 1);
        checkOutput("memwait_req_cycles", cnt, 32'd4);
        checkOutput("memwait_stall", 32'(bus_a.stall_cnt), 32'd3);

        // Timeout on the small instance; the default one keeps waiting
        step(idle, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ld_wait, 1);
            if (bus_b.pc_hold) cnt++;
            checkCycle();
        end
        checkOutput("timeout_holds", cnt, 32'd4);
        checkOutput("timeout_err", 32'(bus_b.mem_err), 32'd1);
        for (int i = 0; i < 3; i++) step(idle, 1);
        checkOutput("timeout_err_sticky", 32'(bus_b.mem_err), 32'd1);

        // Saturation of the 3-bit stall counter
        step(idle, 0);
        checkOutput("err_cleared", 32'(bus_b.mem_err), 32'd0);
        for (int i = 0; i < 9; i++) step(ld_use, 1);
        checkOutput("sat_stall_b", 32'(bus_b.stall_cnt), 32'd7);
        checkOutput("sat_stall_a", 32'(bus_a.stall_cnt), 32'd9);

        // Reset while waiting on memory
        step(ld_wait, 1);
        step(ld_wait, 1);
        step(ld_wait, 0);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0), 1);
        checkOutput("rst_in_wait_req", 32'(bus_a.dmem_req), 32'd0);
        checkCycle();
        checkOutput("rst_in_wait_stall", 32'(bus_a.stall_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            vec_t v;
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.exrd = 5'($urandom_range(0, 3));
            v.use1 = 1'($urandom);
            v.use2 = 1'($urandom);
            v.exmr = 1'($urandom);
            v.br   = ($urandom_range(0, 7) == 0);
            v.zero = 1'($urandom);
            v.mr   = ($urandom_range(0, 5) == 0);
            v.mw   = ($urandom_range(0, 5) == 0);
            v.rdy  = ($urandom_range(0, 9) < 6);
            v.exp  = '0;
            step(v, $urandom_range(0, 63) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core. Drives hold and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three cases:
  - load-use hazards, by inserting one bubble;
  - taken branches resolved in MEM, by flushing the three younger stages;
  - multi-cycle data-memory accesses, using a req/ready handshake with a timeout.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before forced release; valid range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  the ID instruction reads rs1.
- id_use_rs2  in  1  the ID instruction reads rs2.
- ex_MemRead  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- mem_Branch  in  1  EX/MEM Branch_out.
- mem_zero  in  1  EX/MEM zero_out.
- mem_MemRead  in  1  EX/MEM MemRead_out.
- mem_MemWrite  in  1  EX/MEM MemWrite_out.
- dmem_ready  in  1  data memory has completed the current access.
- pc_src  out  1  select the branch target (EX/MEM pc_sum_out).
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- idex_hold  out  1  ID/EX keeps its value.
- exmem_hold  out  1  EX/MEM keeps its value.
- ifid_flush  out  1  IF/ID loads zeros.
- idex_flush  out  1  ID/EX loads zeros.
- exmem_flush  out  1  EX/MEM loads zeros.
- memwb_bubble  out  1  MEM/WB loads a bubble (RegWrite=0).
- dmem_req  out  1  data memory access request.
- mem_err  out  1  sticky flag: a memory timeout occurred.
- stall_cnt  out  CNT_W  number of cycles with pc_hold=1; saturating.
- flush_cnt  out  CNT_W  number of taken branches; saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to RUN;
  - wait counter is cleared;
  - mem_err, stall_cnt and flush_cnt all go to 0.
- While in reset, every combinational output is 0.
- FSM states: RUN, MEM_WAIT. State is held in a register; all control outputs are combinational from state and inputs.
- Terms:
  - br_taken = mem_Branch & mem_zero
  - mem_op = mem_MemRead | mem_MemWrite
  - lu_haz = ex_MemRead & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- RUN, priority order (highest first):
  1. br_taken:
     - pc_src=1; ifid_flush, idex_flush and exmem_flush all =1; no holds;
     - flush_cnt increments;
     - lu_haz and mem_op are ignored. A branch carries no memory op; if mem_op is also set, the branch still wins and dmem_req=0.
  2. mem_op:
     - dmem_req=1.
     - If dmem_ready=1: zero-wait completion; stay in RUN; no holds.
     - If dmem_ready=0: all four holds =1 and memwb_bubble=1; go to MEM_WAIT with the wait counter set to 1.
     - A lu_haz in the same cycle is handled by the holds: idex_flush stays 0 and is re-evaluated after release.
  3. lu_haz:
     - pc_hold=1, ifid_hold=1, idex_flush=1; EX/MEM advances normally.
     - Exactly one bubble per hazard: on the next cycle the load is in MEM, so the hazard clears.
  4. Otherwise: all outputs 0.
- MEM_WAIT:
  - dmem_req=1.
  - If dmem_ready=0 and the wait counter < MEM_TIMEOUT:
    - all four holds =1 and memwb_bubble=1;
    - wait counter increments.
  - If dmem_ready=1: no holds, memwb_bubble=0; go to RUN. The MEM stage completes this cycle.
  - If dmem_ready=0 and the wait counter == MEM_TIMEOUT:
    - treat the cycle as completion; mem_err is set to 1;
    - the access data is undefined, but the pipeline must not deadlock; go to RUN.
  - br_taken and lu_haz are not evaluated in MEM_WAIT. The held instruction in MEM is a memory op.
- stall_cnt increments on every cycle with pc_hold=1 (load-use or memory wait).
- Both counters saturate at all-ones.
- mem_err clears only on reset.
- Hold and flush are never both asserted for the same register.
- Reset asserted in MEM_WAIT: go to RUN, dmem_req drops to 0, and the counters clear.
- Latency: every control decision takes effect at the same clk edge as the condition. There is no registered delay.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → for exactly 1 cycle: pc_hold=1, ifid_hold=1, idex_flush=1; stall_cnt 0→1. With ex_rd=0 → no stall.
- Taken branch: mem_Branch=1, mem_zero=1, with lu_haz also true → pc_src=1, the three flushes =1, pc_hold=0, flush_cnt=1. With mem_zero=0 → no action.
- Memory wait: mem_MemRead=1, dmem_ready low for 3 cycles then high → holds and memwb_bubble =1 for 3 cycles, released in cycle 4, stall_cnt=3, dmem_req high for 4 cycles.
- Zero-wait store: mem_MemWrite=1, dmem_ready=1 → dmem_req=1, no holds, state stays RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → 4 hold cycles, then release; mem_err=1 and stays 1 until rst_n=0.
- Reset in MEM_WAIT plus counter saturation: with CNT_W=3, 9 stall cycles → stall_cnt=7. rst_n=0 in MEM_WAIT → next cycle RUN, dmem_req=0, counters 0.
